// File: rtl/fg_monitor.sv
// fg_monitor: registers the upstream f/g pair, waits out a settle window after reset,
// then counts f rising edges, flags f/g coherence errors and detects runs of f held high.
module fg_monitor #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned RUN_LEN = 3
) (
    input  logic             CLK1,
    input  logic             RST,
    input  logic             f,
    input  logic             g,
    input  logic             clr,
    output logic             ready,
    output logic [CNT_W-1:0] f_rise_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic             run_det
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } run_state_t;

    localparam logic [3:0]       SETTLE_V = 4'(SETTLE);
    localparam logic [3:0]       RUN_V    = 4'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic             f_q, f_d, g_q, g_d, f_prev_q, f_prev_d;
    logic [3:0]       settle_q, settle_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] rise_q, rise_d, err_q, err_d;
    logic             flag_q, flag_d, run_det_q, run_det_d;
    logic [3:0]       run_cnt_q, run_cnt_d;
    run_state_t       state_q, state_d;

    // Input capture, settle window, counters and run FSM next-state logic
    always_comb begin
        f_d       = f;
        g_d       = g;
        f_prev_d  = f_q;
        settle_d  = settle_q;
        ready_d   = ready_q;
        rise_d    = rise_q;
        err_d     = err_q;
        flag_d    = flag_q;
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        run_det_d = 1'b0;

        if (settle_q < SETTLE_V) begin
            settle_d = settle_q + 4'd1;
            ready_d  = ((settle_q + 4'd1) == SETTLE_V) ? 1'b1 : ready_q;
        end else begin
            settle_d = settle_q;
            ready_d  = ready_q;
        end

        // Evaluations use last cycle's captured samples and last cycle's ready
        if (ready_q && f_q && !f_prev_q) begin
            rise_d = sat_inc(rise_q);
        end else begin
            rise_d = rise_q;
        end

        if (ready_q && (f_q == g_q)) begin
            err_d  = sat_inc(err_q);
            flag_d = 1'b1;
        end else begin
            err_d  = err_q;
            flag_d = flag_q;
        end

        if (ready_q) begin
            case (state_q)
                IDLE: begin
                    if (f_q) begin
                        run_cnt_d = 4'd1;
                        if (RUN_V == 4'd1) begin
                            state_d   = HELD;
                            run_det_d = 1'b1;
                        end else begin
                            state_d = COUNT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                COUNT: begin
                    if (!f_q) begin
                        state_d   = IDLE;
                        run_cnt_d = 4'd0;
                    end else begin
                        run_cnt_d = run_cnt_q + 4'd1;
                        if ((run_cnt_q + 4'd1) == RUN_V) begin
                            state_d   = HELD;
                            run_det_d = 1'b1;
                        end else begin
                            state_d = COUNT;
                        end
                    end
                end
                HELD: begin
                    if (!f_q) begin
                        state_d   = IDLE;
                        run_cnt_d = 4'd0;
                    end else begin
                        state_d = HELD;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    run_cnt_d = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // clr overrides any same-cycle update but leaves settling and inputs alone
        if (clr) begin
            rise_d    = {CNT_W{1'b0}};
            err_d     = {CNT_W{1'b0}};
            flag_d    = 1'b0;
            state_d   = IDLE;
            run_cnt_d = 4'd0;
            run_det_d = 1'b0;
        end else begin
            run_cnt_d = run_cnt_d;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK1) begin
        if (RST) begin
            f_q       <= 1'b0;
            g_q       <= 1'b0;
            f_prev_q  <= 1'b0;
            settle_q  <= 4'd0;
            ready_q   <= 1'b0;
            rise_q    <= {CNT_W{1'b0}};
            err_q     <= {CNT_W{1'b0}};
            flag_q    <= 1'b0;
            state_q   <= IDLE;
            run_cnt_q <= 4'd0;
            run_det_q <= 1'b0;
        end else begin
            f_q       <= f_d;
            g_q       <= g_d;
            f_prev_q  <= f_prev_d;
            settle_q  <= settle_d;
            ready_q   <= ready_d;
            rise_q    <= rise_d;
            err_q     <= err_d;
            flag_q    <= flag_d;
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            run_det_q <= run_det_d;
        end
    end

    assign ready      = ready_q;
    assign f_rise_cnt = rise_q;
    assign err_cnt    = err_q;
    assign err_flag   = flag_q;
    assign run_det    = run_det_q;

endmodule

// File: tb/tb_fg_monitor.sv
// Bench for fg_monitor: directed vector table followed by randomized traffic
// compared against a behavioural model of settling, counting and run detection.
module tb_fg_monitor;

    localparam int CNT_W   = 2;
    localparam int SETTLE  = 2;
    localparam int RUN_LEN = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             CLK1 = 1'b0;
    logic             RST  = 1'b1;
    logic             f    = 1'b0;
    logic             g    = 1'b0;
    logic             clr  = 1'b0;
    logic             ready;
    logic [CNT_W-1:0] f_rise_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_flag;
    logic             run_det;

    int checks = 0;
    int errors = 0;

    fg_monitor #(.CNT_W(CNT_W), .SETTLE(SETTLE), .RUN_LEN(RUN_LEN)) dut (
        .CLK1      (CLK1),
        .RST       (RST),
        .f         (f),
        .g         (g),
        .clr       (clr),
        .ready     (ready),
        .f_rise_cnt(f_rise_cnt),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag),
        .run_det   (run_det)
    );

    always #5 CLK1 = ~CLK1;

    typedef struct {
        logic rst, clr, f, g;
        int   rdy, rise, err, flag, run;
    } vec_t;

    vec_t tbl[$];

    // model state: pipeline samples, edges since reset, and an integer run length
    int m_fq, m_gq, m_fprev, m_ready, low_edges;
    int m_rise, m_err, m_flag, m_run_len, m_run;

    task automatic v(input logic r, c, fi, gi, input int rdy, rise, err, flag, run);
        vec_t e;
        e.rst = r; e.clr = c; e.f = fi; e.g = gi;
        e.rdy = rdy; e.rise = rise; e.err = err; e.flag = flag; e.run = run;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, c, fi, gi);
        int rise, err, pulse;
        if (r) begin
            m_fq = 0; m_gq = 0; m_fprev = 0; m_ready = 0; low_edges = 0;
            m_rise = 0; m_err = 0; m_flag = 0; m_run_len = 0; m_run = 0;
        end else begin
            rise  = (m_ready != 0 && m_fq != 0 && m_fprev == 0) ? 1 : 0;
            err   = (m_ready != 0 && m_fq == m_gq) ? 1 : 0;
            pulse = 0;
            if (m_ready != 0) begin
                if (m_fq != 0) begin
                    m_run_len++;
                    pulse = (m_run_len == RUN_LEN) ? 1 : 0;
                end else begin
                    m_run_len = 0;
                end
            end
            if (c) begin
                m_rise = 0; m_err = 0; m_flag = 0; m_run_len = 0; m_run = 0;
            end else begin
                if (rise != 0 && m_rise < CMAX) m_rise++;
                if (err != 0 && m_err < CMAX) m_err++;
                if (err != 0) m_flag = 1;
                m_run = pulse;
            end
            low_edges++;
            m_ready = (low_edges >= SETTLE) ? 1 : 0;
            m_fprev = m_fq;
            m_fq    = int'(fi);
            m_gq    = int'(gi);
        end
    endtask

    task automatic step(input logic r, c, fi, gi);
        RST = r; clr = c; f = fi; g = gi;
        @(posedge CLK1);
        model_edge(r, c, fi, gi);
        #1;
    endtask

    initial begin
        logic r, c, fi, gi;

        // settle gating with f==g from the first low cycle, then saturation and clr
        v(1,0,0,0, 0,0,0,0,0); v(1,0,0,0, 0,0,0,0,0);
        v(0,0,1,1, 0,0,0,0,0); v(0,0,1,1, 1,0,0,0,0);
        v(0,0,1,1, 1,0,1,1,0); v(0,0,1,1, 1,0,2,1,0);
        v(0,0,1,1, 1,0,3,1,1); v(0,0,1,1, 1,0,3,1,0);
        v(0,1,0,1, 1,0,0,0,0);
        // rise counting with coherent g
        v(0,0,0,1, 1,0,0,0,0); v(0,0,1,0, 1,0,0,0,0);
        v(0,0,0,1, 1,1,0,0,0); v(0,0,1,0, 1,1,0,0,0);
        v(0,0,0,1, 1,2,0,0,0); v(0,0,1,0, 1,2,0,0,0);
        v(0,0,0,1, 1,3,0,0,0); v(0,0,0,1, 1,3,0,0,0);
        v(0,1,0,1, 1,0,0,0,0);
        // run detect: 5 high, 1 low, 2 high
        v(0,0,1,0, 1,0,0,0,0); v(0,0,1,0, 1,1,0,0,0);
        v(0,0,1,0, 1,1,0,0,0); v(0,0,1,0, 1,1,0,0,1);
        v(0,0,1,0, 1,1,0,0,0); v(0,0,0,1, 1,1,0,0,0);
        v(0,0,1,0, 1,1,0,0,0); v(0,0,1,0, 1,2,0,0,0);
        v(0,0,0,1, 1,2,0,0,0); v(0,0,0,1, 1,2,0,0,0);
        v(0,0,0,1, 1,2,0,0,0);
        // err_cnt saturation with f=g=0
        v(0,0,0,0, 1,2,0,0,0); v(0,0,0,0, 1,2,1,1,0);
        v(0,0,0,0, 1,2,2,1,0); v(0,0,0,0, 1,2,3,1,0);
        v(0,0,0,0, 1,2,3,1,0); v(0,0,0,0, 1,2,3,1,0);
        // clr on the same edge as an error and a run pulse; FSM must restart from IDLE
        v(0,0,1,1, 1,2,3,1,0); v(0,0,1,1, 1,3,3,1,0);
        v(0,0,1,1, 1,3,3,1,0); v(0,1,1,1, 1,0,0,0,0);
        v(0,0,1,1, 1,0,1,1,0); v(0,0,1,1, 1,0,2,1,0);
        v(0,0,0,1, 1,0,3,1,1);
        // reset two samples into a run, then full settle and a fresh run
        v(0,0,1,0, 1,0,3,1,0); v(0,0,1,0, 1,1,3,1,0);
        v(0,0,1,0, 1,1,3,1,0); v(1,0,1,0, 0,0,0,0,0);
        v(0,0,1,0, 0,0,0,0,0); v(0,0,1,0, 1,0,0,0,0);
        v(0,0,1,0, 1,0,0,0,0); v(0,0,1,0, 1,0,0,0,0);
        v(0,0,1,0, 1,0,0,0,1);

        #2;
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].clr, tbl[i].f, tbl[i].g);
            chk($sformatf("vec%0d ready", i),    int'(ready),      tbl[i].rdy);
            chk($sformatf("vec%0d rise_cnt", i), int'(f_rise_cnt), tbl[i].rise);
            chk($sformatf("vec%0d err_cnt", i),  int'(err_cnt),    tbl[i].err);
            chk($sformatf("vec%0d err_flag", i), int'(err_flag),   tbl[i].flag);
            chk($sformatf("vec%0d run_det", i),  int'(run_det),    tbl[i].run);
        end

        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            c  = ($urandom_range(0, 19) == 0);
            fi = ($urandom_range(0, 2) != 0);
            gi = ($urandom_range(0, 5) == 0) ? fi : ~fi;
            step(r, c, fi, gi);
            chk("rnd ready",    int'(ready),      m_ready);
            chk("rnd rise_cnt", int'(f_rise_cnt), m_rise);
            chk("rnd err_cnt",  int'(err_cnt),    m_err);
            chk("rnd err_flag", int'(err_flag),   m_flag);
            chk("rnd run_det",  int'(run_det),    m_run);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
